ili934x_win_blit: RTL and testbench

- Parametrised successor to the ILI934x window/stream controller.
- Takes one blit request (window + pixel source) and emits CASET (2A) + 4 bytes, PASET (2B) + 4 bytes, RAMWR (2C), then exactly width*height pixels of BYTES_PER_PIX bytes each, MSB first.
- Output is a registered wr_item_t stream with a true valid/ready handshake. It feeds the command/data FIFO in front of the SPI/8080 serializer.
- Adds window validation, pixel counting, abort at pixel boundary, and done/err status.

---
 rtl/ili934x_pkg.sv | 24 ++
 rtl/ili934x_item_slot.sv | 31 +++
 rtl/ili934x_win_blit.sv | 259 +++++++++++++++++++++++++
 tb/tb_ili934x_win_blit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ili934x_pkg.sv
// Shared types and opcodes for the ILI934x command/data generators.
package ili934x_pkg;

  typedef struct packed {
    logic       is_cmd;
    logic [7:0] data;
  } wr_item_t;

  localparam logic [7:0] ILI_CASET = 8'h2A;
  localparam logic [7:0] ILI_PASET = 8'h2B;
  localparam logic [7:0] ILI_RAMWR = 8'h2C;

  // Index of the RAMWR step in the 11-item window header.
  localparam logic [3:0] HDR_LAST = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    HDR,
    PIX,
    DRAIN
  } blit_state_e;

endpackage

// File: rtl/ili934x_item_slot.sv
// One-entry registered valid/ready output stage. The producer may only load
// when loadable is high, so a stalled item never changes under the consumer.
module ili934x_item_slot
  import ili934x_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  wr_item_t load_item,
  output logic     loadable,
  output logic     item_valid,
  output wr_item_t item,
  input  logic     item_ready
);

  assign loadable = !item_valid || item_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      item_valid <= 1'b0;
      item       <= '0;
    end else if (load && loadable) begin
      item_valid <= 1'b1;
      item       <= load_item;
    end else if (item_ready) begin
      item_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ili934x_win_blit.sv
// Window blit controller: CASET/PASET/RAMWR header then width*height pixels, MSB first.
// Define ILI934X_BLIT_FILL_EN to add fill_mode/fill_color (internally generated solid fill).
module ili934x_win_blit
  import ili934x_pkg::*;
#(
  parameter int         BYTES_PER_PIX = 2,
  parameter int         PIX_CNT_W     = 17,
  parameter logic [7:0] CMD_CASET     = ILI_CASET,
  parameter logic [7:0] CMD_PASET     = ILI_PASET,
  parameter logic [7:0] CMD_RAMWR     = ILI_RAMWR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       blit_start,
  input  logic [15:0]                win_x0,
  input  logic [15:0]                win_y0,
  input  logic [15:0]                win_x1,
  input  logic [15:0]                win_y1,
  input  logic                       abort,
  input  logic [8*BYTES_PER_PIX-1:0] pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
`ifdef ILI934X_BLIT_FILL_EN
  input  logic                       fill_mode,
  input  logic [8*BYTES_PER_PIX-1:0] fill_color,
`endif
  output logic                       item_valid,
  output wr_item_t                   item,
  input  logic                       item_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       aborted,
  output logic [PIX_CNT_W:0]         pix_left
);

  localparam int          PW        = 8 * BYTES_PER_PIX;
  localparam logic [33:0] MAX_AREA  = 34'd1 << PIX_CNT_W;
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_PIX - 1);

  if (BYTES_PER_PIX != 2 && BYTES_PER_PIX != 3) begin : g_bpp_check
    $error("ili934x_win_blit: BYTES_PER_PIX must be 2 or 3");
  end

  blit_state_e          state_q, state_d;
  logic [3:0]           hdr_idx_q, hdr_idx_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [PW-1:0]        shift_q, shift_d;
  logic [PIX_CNT_W:0]   pix_left_q, pix_left_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic [15:0]          x0_q, y0_q, x1_q, y1_q;
  logic                 latch_win;

  logic                 slot_load, slot_loadable;
  wr_item_t             slot_item, hdr_item;

  logic [16:0]          win_w, win_h;
  logic [33:0]          win_area;
  logic                 win_bad;

  logic [PW-1:0]        src_word;
  logic                 src_valid, ext_src;
  logic                 can_take, take;

  // Width/height are one wider than the coordinates so a full 65536 span fits.
  always_comb begin
    win_w    = {1'b0, win_x1} - {1'b0, win_x0} + 17'd1;
    win_h    = {1'b0, win_y1} - {1'b0, win_y0} + 17'd1;
    win_area = {17'd0, win_w} * {17'd0, win_h};
    win_bad  = (win_x1 < win_x0) || (win_y1 < win_y0) || (win_area > MAX_AREA);
  end

`ifdef ILI934X_BLIT_FILL_EN
  logic          fill_q;
  logic [PW-1:0] color_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= 1'b0;
      color_q <= '0;
    end else if (latch_win) begin
      fill_q  <= fill_mode;
      color_q <= fill_color;
    end
  end

  assign src_word  = fill_q ? color_q : pix_data;
  assign src_valid = fill_q || pix_valid;
  assign ext_src   = !fill_q;
`else
  assign src_word  = pix_data;
  assign src_valid = pix_valid;
  assign ext_src   = 1'b1;
`endif

  ili934x_item_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (slot_load),
    .load_item  (slot_item),
    .loadable   (slot_loadable),
    .item_valid (item_valid),
    .item       (item),
    .item_ready (item_ready)
  );

  // Step 0 (CASET) is loaded straight from IDLE so the first item appears one cycle after start.
  always_comb begin
    hdr_item = '0;
    case (hdr_idx_q)
      4'd0:    hdr_item = '{is_cmd: 1'b1, data: CMD_CASET};
      4'd1:    hdr_item = '{is_cmd: 1'b0, data: x0_q[15:8]};
      4'd2:    hdr_item = '{is_cmd: 1'b0, data: x0_q[7:0]};
      4'd3:    hdr_item = '{is_cmd: 1'b0, data: x1_q[15:8]};
      4'd4:    hdr_item = '{is_cmd: 1'b0, data: x1_q[7:0]};
      4'd5:    hdr_item = '{is_cmd: 1'b1, data: CMD_PASET};
      4'd6:    hdr_item = '{is_cmd: 1'b0, data: y0_q[15:8]};
      4'd7:    hdr_item = '{is_cmd: 1'b0, data: y0_q[7:0]};
      4'd8:    hdr_item = '{is_cmd: 1'b0, data: y1_q[15:8]};
      4'd9:    hdr_item = '{is_cmd: 1'b0, data: y1_q[7:0]};
      4'd10:   hdr_item = '{is_cmd: 1'b1, data: CMD_RAMWR};
      default: hdr_item = '0;
    endcase
  end

  assign can_take  = (state_q == PIX) && (byte_idx_q == 2'd0) && slot_loadable &&
                     !abort_pend_q && (pix_left_q != '0);
  assign take      = can_take && src_valid;
  assign pix_ready = can_take && ext_src;

  // NOTE: every always_comb output gets a default first; otherwise a missed branch infers a latch.
  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    pix_left_d   = pix_left_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    latch_win    = 1'b0;
    slot_load    = 1'b0;
    slot_item    = '0;

    case (state_q)
      IDLE: begin
        pix_left_d   = '0;
        abort_pend_d = 1'b0;
        byte_idx_d   = 2'd0;
        if (blit_start) begin
          if (win_bad) begin
            state_d = ERR;
          end else begin
            latch_win  = 1'b1;
            slot_load  = 1'b1;
            slot_item  = '{is_cmd: 1'b1, data: CMD_CASET};
            hdr_idx_d  = 4'd1;
            pix_left_d = win_area[PIX_CNT_W:0];
            state_d    = HDR;
          end
        end
      end

      ERR: state_d = IDLE;

      HDR: begin
        if (slot_loadable) begin
          slot_load = 1'b1;
          slot_item = hdr_item;
          hdr_idx_d = hdr_idx_q + 4'd1;
          if (abort) begin
            abort_pend_d = 1'b1;
            state_d      = DRAIN;
          end else if (hdr_idx_q == HDR_LAST) begin
            state_d = PIX;
          end
        end
      end

      PIX: begin
        if (abort) abort_pend_d = 1'b1;
        if (byte_idx_q == 2'd0) begin
          if (abort_pend_q || pix_left_q == '0) begin
            state_d = DRAIN;
          end else if (take) begin
            slot_load  = 1'b1;
            slot_item  = '{is_cmd: 1'b0, data: src_word[PW-1 -: 8]};
            shift_d    = src_word << 8;
            byte_idx_d = 2'd1;
            pix_left_d = pix_left_q - {{PIX_CNT_W{1'b0}}, 1'b1};
          end
        end else if (slot_loadable) begin
          // Remaining bytes of the current pixel go out regardless of abort.
          slot_load = 1'b1;
          slot_item = '{is_cmd: 1'b0, data: shift_q[PW-1 -: 8]};
          shift_d   = shift_q << 8;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = 2'd0;
            if (pix_left_q == '0 || abort_pend_q || abort) state_d = DRAIN;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      DRAIN: begin
        if (slot_loadable) begin
          state_d    = IDLE;
          done_d     = !abort_pend_q;
          aborted_d  = abort_pend_q;
          pix_left_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hdr_idx_q    <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      pix_left_q   <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      pix_left_q   <= pix_left_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      if (latch_win) begin
        x0_q <= win_x0;
        y0_q <= win_y0;
        x1_q <= win_x1;
        y1_q <= win_y1;
      end
    end
  end

  assign busy     = (state_q == HDR) || (state_q == PIX) || (state_q == DRAIN);
  assign err      = (state_q == ERR);
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign pix_left = pix_left_q;

endmodule

// File: tb/tb_ili934x_win_blit.sv
// Self-checking bench for ili934x_win_blit: table-driven blits plus random windows/pixels
// against a byte-stream model, and a 3-byte-per-pixel instance for the RGB666 corner cases.
module tb_ili934x_win_blit;
  import ili934x_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        blit_start, abort, pix_valid, pix_ready, item_valid, item_ready;
  logic [15:0] win_x0, win_y0, win_x1, win_y1, pix_data;
  wr_item_t    item;
  logic        busy, done, err, aborted;
  logic [17:0] pix_left;

  logic        d3_start, d3_pix_valid, d3_pix_ready, d3_item_valid, d3_item_ready;
  logic [15:0] d3_x0, d3_y0, d3_x1, d3_y1;
  logic [23:0] d3_pix_data;
  wr_item_t    d3_item;
  logic        d3_busy, d3_done, d3_err, d3_aborted;
  logic [16:0] d3_pix_left;

`ifdef ILI934X_BLIT_FILL_EN
  logic        fill_mode = 1'b0;
  logic [15:0] fill_color = '0;
  logic [23:0] d3_fill_color = '0;
`endif

  ili934x_win_blit u_dut (
    .clk(clk), .rst(rst), .blit_start(blit_start),
    .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
    .abort(abort), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
`ifdef ILI934X_BLIT_FILL_EN
    .fill_mode(fill_mode), .fill_color(fill_color),
`endif
    .item_valid(item_valid), .item(item), .item_ready(item_ready),
    .busy(busy), .done(done), .err(err), .aborted(aborted), .pix_left(pix_left)
  );

  ili934x_win_blit #(.BYTES_PER_PIX(3), .PIX_CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .blit_start(d3_start),
    .win_x0(d3_x0), .win_y0(d3_y0), .win_x1(d3_x1), .win_y1(d3_y1),
    .abort(1'b0), .pix_data(d3_pix_data), .pix_valid(d3_pix_valid), .pix_ready(d3_pix_ready),
`ifdef ILI934X_BLIT_FILL_EN
    .fill_mode(fill_mode), .fill_color(d3_fill_color),
`endif
    .item_valid(d3_item_valid), .item(d3_item), .item_ready(d3_item_ready),
    .busy(d3_busy), .done(d3_done), .err(d3_err), .aborted(d3_aborted), .pix_left(d3_pix_left)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] x0, y0, x1, y1;
    int          rdy_mode;   // 0 always ready, 1 toggling 1010.., 2 random
    int          gap_pct;    // chance of a pix_valid gap per cycle
    int          abort_at;   // raise abort once this many items were accepted (-1 never)
    bit          fixed;      // use the F800/07E0 pixel pair
    bit          exp_err;
    int          exp_npix;   // pixels that must appear in the stream
    bit          exp_abort;
  } vec_t;

  logic [15:0] pix_src[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];

  // Reference stream: 11 header items, then whole pixels MSB first.
  task automatic build_exp(input vec_t v, input int npix);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h2A});
    exp_q.push_back({1'b0, v.x0[15:8]}); exp_q.push_back({1'b0, v.x0[7:0]});
    exp_q.push_back({1'b0, v.x1[15:8]}); exp_q.push_back({1'b0, v.x1[7:0]});
    exp_q.push_back({1'b1, 8'h2B});
    exp_q.push_back({1'b0, v.y0[15:8]}); exp_q.push_back({1'b0, v.y0[7:0]});
    exp_q.push_back({1'b0, v.y1[15:8]}); exp_q.push_back({1'b0, v.y1[7:0]});
    exp_q.push_back({1'b1, 8'h2C});
    for (int i = 0; i < npix; i++) begin
      exp_q.push_back({1'b0, pix_src[i][15:8]});
      exp_q.push_back({1'b0, pix_src[i][7:0]});
    end
  endtask

  function automatic bit win_err(input logic [15:0] x0, y0, x1, y1, input longint max_area);
    longint w, h;
    w = longint'(x1) - longint'(x0) + 1;
    h = longint'(y1) - longint'(y0) + 1;
    return (w < 1) || (h < 1) || (w * h > max_area);
  endfunction

  task automatic run_blit(input vec_t v, input string tag);
    longint w, h;
    int total, pix_i, last_hs, fin_cyc, exp_pl;
    bit saw_done, saw_err, saw_ab, ab_drive, prev_stall;
    wr_item_t prev_item;
    w = longint'(v.x1) - longint'(v.x0) + 1;
    h = longint'(v.y1) - longint'(v.y0) + 1;
    total = v.exp_err ? 0 : int'(w * h);
    pix_src.delete();
    if (v.fixed) begin
      pix_src.push_back(16'hF800);
      pix_src.push_back(16'h07E0);
    end else begin
      for (int i = 0; i < total; i++) pix_src.push_back(16'($urandom));
    end
    got_q.delete();
    pix_i = 0; last_hs = 0; fin_cyc = 0;
    saw_done = 0; saw_err = 0; saw_ab = 0; ab_drive = 0; prev_stall = 0; prev_item = '0;

    win_x0 = v.x0; win_y0 = v.y0; win_x1 = v.x1; win_y1 = v.y1;
    blit_start = 1'b1; abort = 1'b0; pix_valid = 1'b0; item_ready = 1'b1;
    @(posedge clk); #1;
    blit_start = 1'b0;
    win_x0 = 16'($urandom); win_y0 = 16'($urandom);
    win_x1 = 16'($urandom); win_y1 = 16'($urandom);

    for (int cyc = 1; cyc <= 400; cyc++) begin
      case (v.rdy_mode)
        0:       item_ready = 1'b1;
        1:       item_ready = cyc[0];
        default: item_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (pix_i < pix_src.size() && $urandom_range(0, 99) >= v.gap_pct) begin
        pix_valid = 1'b1;
        pix_data  = pix_src[pix_i];
      end else begin
        pix_valid = 1'b0;
        pix_data  = 16'($urandom);
      end
      abort = ab_drive;
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, ".busy_first"}, busy, !v.exp_err);
        check({tag, ".valid_first"}, item_valid, !v.exp_err);
        check({tag, ".err_first"}, err, v.exp_err);
      end
      exp_pl = (done || aborted) ? 0 : total - pix_i;
      check({tag, ".pix_left"}, pix_left, exp_pl);
      if (prev_stall) begin
        check({tag, ".stall_valid"}, item_valid, 1'b1);
        check({tag, ".stall_item"}, item, prev_item);
      end
      prev_stall = item_valid && !item_ready;
      prev_item  = item;
      if (item_valid && item_ready) begin
        got_q.push_back(item);
        last_hs = cyc;
      end
      if (pix_valid && pix_ready) pix_i++;
      if (v.abort_at >= 0 && got_q.size() >= v.abort_at) ab_drive = 1'b1;
      if (done || err || aborted) begin
        saw_done = done; saw_err = err; saw_ab = aborted; fin_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end

    check({tag, ".finished"}, fin_cyc != 0, 1'b1);
    check({tag, ".err"}, saw_err, v.exp_err);
    check({tag, ".done"}, saw_done, !v.exp_err && !v.exp_abort);
    check({tag, ".aborted"}, saw_ab, v.exp_abort);
    check({tag, ".busy_end"}, busy, 1'b0);
    check({tag, ".pix_acc"}, pix_i, v.exp_npix);
    if (!v.exp_err) check({tag, ".end_latency"}, fin_cyc, last_hs + 1);
    if (!v.exp_err && v.rdy_mode == 0 && v.gap_pct == 0 && v.abort_at < 0)
      check({tag, ".no_bubble"}, fin_cyc, 12 + 2 * total);
    if (v.exp_err) exp_q.delete();
    else build_exp(v, v.exp_npix);
    check({tag, ".n_items"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.item%0d", tag, i), got_q[i], exp_q[i]);

    @(posedge clk); #1;
    abort = 1'b0; pix_valid = 1'b0; item_ready = 1'b1;
    @(negedge clk);
    check({tag, ".pulse_len"}, {done, err, aborted}, 3'b000);
    check({tag, ".idle_valid"}, item_valid, 1'b0);
  endtask

  task automatic run_bpp3();
    logic [8:0] d3_exp[14];
    logic [8:0] d3_got[$];
    int acc, acc_cyc, fin_cyc;
    d3_exp = '{9'h12A, 9'h000, 9'h000, 9'h000, 9'h000, 9'h12B, 9'h000, 9'h000,
               9'h000, 9'h000, 9'h12C, 9'h0FC, 9'h080, 9'h040};
    acc = 0; acc_cyc = -10; fin_cyc = 0;
    d3_x0 = 16'd0; d3_y0 = 16'd0; d3_x1 = 16'd0; d3_y1 = 16'd0;
    d3_start = 1'b1; d3_item_ready = 1'b1; d3_pix_valid = 1'b0;
    @(posedge clk); #1;
    d3_start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      d3_pix_valid = 1'b1;
      d3_pix_data  = (acc == 0) ? 24'hFC8040 : 24'h123456;
      @(negedge clk);
      if (cyc == acc_cyc + 1 || cyc == acc_cyc + 2)
        check("bpp3.ready_pending", d3_pix_ready, 1'b0);
      if (d3_item_valid && d3_item_ready) d3_got.push_back(d3_item);
      if (d3_pix_valid && d3_pix_ready) begin
        acc++;
        acc_cyc = cyc;
      end
      if (d3_done) begin
        fin_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("bpp3.done_cycle", fin_cyc, 15);
    check("bpp3.pix_acc", acc, 1);
    check("bpp3.n_items", d3_got.size(), 14);
    for (int i = 0; i < 14 && i < d3_got.size(); i++)
      check($sformatf("bpp3.item%0d", i), d3_got[i], d3_exp[i]);

    // 320x240 = 76800 pixels overflows a 16-bit pixel counter range.
    @(posedge clk); #1;
    d3_pix_valid = 1'b0;
    d3_x0 = 16'd0; d3_y0 = 16'd0; d3_x1 = 16'd319; d3_y1 = 16'd239;
    d3_start = 1'b1;
    @(posedge clk); #1;
    d3_start = 1'b0;
    @(negedge clk);
    check("bpp3.big_err", d3_err, 1'b1);
    check("bpp3.big_busy", d3_busy, 1'b0);
    check("bpp3.big_valid", d3_item_valid, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; blit_start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
    item_ready = 1'b1; win_x0 = '0; win_y0 = '0; win_x1 = '0; win_y1 = '0;
    d3_start = 1'b0; d3_pix_valid = 1'b0; d3_pix_data = '0; d3_item_ready = 1'b1;
    d3_x0 = '0; d3_y0 = '0; d3_x1 = '0; d3_y1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.item_valid", item_valid, 1'b0);
    check("reset.item", item, 9'h000);
    check("reset.status", {busy, done, err, aborted}, 4'b0000);
    check("reset.pix_left", pix_left, 18'd0);
    check("reset.pix_ready", pix_ready, 1'b0);
    @(posedge clk); #1;

    //          x0        y0        x1        y1     rdy gap abort fixed err npix abort
    vecs[0] = '{16'd0,    16'd0,    16'd1,    16'd0,   0,  0,  -1,  1,   0,  2,   0};
    vecs[1] = '{16'd0,    16'd0,    16'd1,    16'd0,   1,  0,  -1,  1,   0,  2,   0};
    vecs[2] = '{16'd9,    16'd0,    16'd5,    16'd0,   0,  0,  -1,  0,   1,  0,   0};
    vecs[3] = '{16'd0,    16'd7,    16'd3,    16'd5,   0,  0,  -1,  0,   1,  0,   0};
    vecs[4] = '{16'd0,    16'd0,    16'd511,  16'd256, 0,  0,  -1,  0,   1,  0,   0};
    vecs[5] = '{16'd10,   16'd20,   16'd12,   16'd21,  2,  30, -1,  0,   0,  6,   0};
    vecs[6] = '{16'd0,    16'd0,    16'd3,    16'd0,   0,  0,  13,  0,   0,  2,   1};
    vecs[7] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 50, -1,  0,   0,  2,   0};

    for (int i = 0; i < 8; i++) run_blit(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.x0 = 16'($urandom_range(0, 400));
      v.y0 = 16'($urandom_range(0, 300));
      v.x1 = v.x0 + 16'($urandom_range(0, 3));
      v.y1 = v.y0 + 16'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0 && v.x0 != 0) v.x1 = v.x0 - 16'd1;
      v.rdy_mode  = 2;
      v.gap_pct   = $urandom_range(0, 50);
      v.abort_at  = -1;
      v.fixed     = 1'b0;
      v.exp_err   = win_err(v.x0, v.y0, v.x1, v.y1, 131072);
      v.exp_npix  = v.exp_err ? 0 :
                    int'((longint'(v.x1) - longint'(v.x0) + 1) * (longint'(v.y1) - longint'(v.y0) + 1));
      v.exp_abort = 1'b0;
      run_blit(v, $sformatf("rnd%0d", r));
    end

    // Reset while the header is at step 4.
    win_x0 = 16'd0; win_y0 = 16'd0; win_x1 = 16'd1; win_y1 = 16'd0;
    item_ready = 1'b1; blit_start = 1'b1;
    @(posedge clk); #1;
    blit_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst.item_valid", item_valid, 1'b0);
    check("midrst.busy", busy, 1'b0);
    check("midrst.pix_left", pix_left, 18'd0);
    check("midrst.done", done, 1'b0);
    @(posedge clk); #1;
    run_blit(vecs[0], "after_rst");

    run_bpp3();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
